// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, one-shot pulse field
// and a saturating backpressure counter. in_ready comes straight from a register.
module pipe_skid_reg #(
    parameter int DATA_W  = 128,
    parameter int CTRL_W  = 8,
    parameter int PULSE_W = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [PULSE_W-1:0] in_pulse,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    output logic [PULSE_W-1:0] out_pulse,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   bp_count
);

    logic               main_valid_reg, main_valid_next;
    logic [CTRL_W-1:0]  main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0]  main_data_reg, main_data_next;
    logic [PULSE_W-1:0] main_pulse_reg, main_pulse_next;
    logic               skid_valid_reg, skid_valid_next;
    logic [CTRL_W-1:0]  skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0]  skid_data_reg, skid_data_next;
    logic [PULSE_W-1:0] skid_pulse_reg, skid_pulse_next;
    logic [CNT_W-1:0]   bp_count_reg, bp_count_next;

    logic acc;
    logic drn;

    assign in_ready = !skid_valid_reg;
    assign acc      = in_valid && in_ready;
    assign drn      = main_valid_reg && out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_ctrl_next  = main_ctrl_reg;
        main_data_next  = main_data_reg;
        main_pulse_next = main_pulse_reg;
        skid_valid_next = skid_valid_reg;
        skid_ctrl_next  = skid_ctrl_reg;
        skid_data_next  = skid_data_reg;
        skid_pulse_next = skid_pulse_reg;

        // A beat that survives a cycle in main has already shown its pulse.
        if (main_valid_reg && !drn) begin
            main_pulse_next = '0;
        end

        if (flush) begin
            main_valid_next = 1'b0;
            main_ctrl_next  = '0;
            main_data_next  = '0;
            main_pulse_next = '0;
            skid_valid_next = 1'b0;
            skid_ctrl_next  = '0;
            skid_data_next  = '0;
            skid_pulse_next = '0;
        end else if (skid_valid_reg) begin
            if (drn) begin
                main_ctrl_next  = skid_ctrl_reg;
                main_data_next  = skid_data_reg;
                main_pulse_next = skid_pulse_reg;
                skid_valid_next = 1'b0;
                skid_ctrl_next  = '0;
                skid_pulse_next = '0;
            end
        end else if (main_valid_reg) begin
            if (acc && drn) begin
                main_ctrl_next  = in_ctrl;
                main_data_next  = in_data;
                main_pulse_next = in_pulse;
            end else if (acc) begin
                skid_valid_next = 1'b1;
                skid_ctrl_next  = in_ctrl;
                skid_data_next  = in_data;
                skid_pulse_next = in_pulse;
            end else if (drn) begin
                // Bubble: ctrl and pulse go to zero, data keeps its last value.
                main_valid_next = 1'b0;
                main_ctrl_next  = '0;
                main_pulse_next = '0;
            end
        end else if (acc) begin
            main_valid_next = 1'b1;
            main_ctrl_next  = in_ctrl;
            main_data_next  = in_data;
            main_pulse_next = in_pulse;
        end
    end

    always_comb begin
        bp_count_next = bp_count_reg;
        if (main_valid_reg && !out_ready && (bp_count_reg != {CNT_W{1'b1}})) begin
            bp_count_next = bp_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_ctrl_reg  <= '0;
            main_data_reg  <= '0;
            main_pulse_reg <= '0;
            skid_valid_reg <= 1'b0;
            skid_ctrl_reg  <= '0;
            skid_data_reg  <= '0;
            skid_pulse_reg <= '0;
            bp_count_reg   <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_ctrl_reg  <= main_ctrl_next;
            main_data_reg  <= main_data_next;
            main_pulse_reg <= main_pulse_next;
            skid_valid_reg <= skid_valid_next;
            skid_ctrl_reg  <= skid_ctrl_next;
            skid_data_reg  <= skid_data_next;
            skid_pulse_reg <= skid_pulse_next;
            bp_count_reg   <= bp_count_next;
        end
    end

    assign out_valid = main_valid_reg;
    assign out_ctrl  = main_ctrl_reg;
    assign out_data  = main_data_reg;
    assign out_pulse = main_pulse_reg;
    assign occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};
    assign bp_count  = bp_count_reg;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the stage.
`timescale 1ns/1ps
module tb_pipe_skid_reg;
    localparam int DATA_W  = 128;
    localparam int CTRL_W  = 8;
    localparam int PULSE_W = 1;
    localparam int CNT_W   = 4;
    localparam int BP_MAX  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [CTRL_W-1:0]  in_ctrl;
    logic [DATA_W-1:0]  in_data;
    logic [PULSE_W-1:0] in_pulse;
    logic               out_valid;
    logic               out_ready;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [DATA_W-1:0]  out_data;
    logic [PULSE_W-1:0] out_pulse;
    logic [1:0]         occupancy;
    logic [CNT_W-1:0]   bp_count;

    pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .PULSE_W(PULSE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_data(in_data), .in_pulse(in_pulse),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_pulse(out_pulse),
        .occupancy(occupancy), .bp_count(bp_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CTRL_W-1:0]  c;
        logic [DATA_W-1:0]  d;
        logic [PULSE_W-1:0] p;
    } beat_t;

    // Model: FIFO of held beats, whether the head is on its first cycle,
    // the last data value shown, and the stall-cycle count.
    beat_t       q[$];
    bit          m_fresh;
    logic [DATA_W-1:0] m_last;
    int          m_bp;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fresh = 1'b0;
        m_last  = '0;
        m_bp    = 0;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d, input logic [PULSE_W-1:0] p);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
        in_pulse = p;
    endtask

    // One clock: compare all outputs to the model mid-cycle, then advance the
    // model with the inputs the DUT sees at the edge. Returns #1 after the edge.
    task automatic tick();
        int    n;
        bit    acc;
        bit    drn;
        bit    stays;
        beat_t b;
        @(negedge clk);
        n = q.size();
        chk("out_valid", 128'(out_valid), 128'(n > 0));
        chk("out_ctrl",  128'(out_ctrl),  (n > 0) ? 128'(q[0].c) : 128'(0));
        chk("out_data",  128'(out_data),  (n > 0) ? 128'(q[0].d) : 128'(m_last));
        chk("out_pulse", 128'(out_pulse), (n > 0 && m_fresh) ? 128'(q[0].p) : 128'(0));
        chk("in_ready",  128'(in_ready),  128'(n < 2));
        chk("occupancy", 128'(occupancy), 128'(n));
        chk("bp_count",  128'(bp_count),  128'(m_bp));
        @(posedge clk);
        acc = in_valid && (n < 2);
        drn = (n > 0) && out_ready;
        if (n > 0 && !out_ready && m_bp < BP_MAX) m_bp++;
        if (flush) begin
            if (n > 0) $display("flush drops %0d beat(s)", n);
            q.delete();
            m_last = '0;
        end else begin
            stays = (n > 0) && !drn;
            if (drn) begin
                $display("beat out ctrl=%0h data=%0h", q[0].c, q[0].d);
                m_last = q[0].d;
                void'(q.pop_front());
            end
            if (acc) begin
                b.c = in_ctrl;
                b.d = in_data;
                b.p = in_pulse;
                q.push_back(b);
            end
            m_fresh = !stays;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_out_data",  128'(out_data),  128'(0));
        rst = 1'b0;
        chk("rst_in_ready",  128'(in_ready),  128'(1));

        // Streaming: 4 back-to-back beats with out_ready high.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'h11, DATA_W'(i), 1'b1);
            tick();
            chk("stream_data",  128'(out_data),  128'(i));
            chk("stream_pulse", 128'(out_pulse), 128'(1));
            chk("stream_occ",   128'(occupancy), 128'(1));
        end
        drive(1'b0, '0, '0, '0);
        tick();
        chk("stream_end_valid", 128'(out_valid), 128'(0));
        chk("stream_bp",        128'(bp_count),  128'(0));

        // Skid fill with A then B, then drain; also checks the one-shot pulse.
        out_ready = 1'b0;
        drive(1'b1, 8'h0A, 128'hA, 1'b1);
        tick();
        chk("skid_occ1",   128'(occupancy), 128'(1));
        chk("skid_pulseA", 128'(out_pulse), 128'(1));
        drive(1'b1, 8'h0B, 128'hB, 1'b1);
        tick();
        chk("skid_occ2",    128'(occupancy), 128'(2));
        chk("skid_inready", 128'(in_ready),  128'(0));
        chk("skid_pulse_2", 128'(out_pulse), 128'(0));
        drive(1'b0, '0, '0, '0);
        tick();
        chk("skid_dataA",   128'(out_data),  128'hA);
        chk("skid_pulse_3", 128'(out_pulse), 128'(0));
        out_ready = 1'b1;
        tick();
        chk("skid_dataB",   128'(out_data),  128'hB);
        chk("skid_promote_pulse", 128'(out_pulse), 128'(1));
        tick();
        chk("skid_empty_valid", 128'(out_valid), 128'(0));
        chk("skid_empty_ctrl",  128'(out_ctrl),  128'(0));
        chk("skid_hold_data",   128'(out_data),  128'hB);

        // Flush while FULL with an incoming beat.
        out_ready = 1'b0;
        drive(1'b1, 8'h21, 128'h21, 1'b1);
        tick();
        drive(1'b1, 8'h22, 128'h22, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 8'h5A, 128'hDEAD, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("flush_valid",   128'(out_valid), 128'(0));
        chk("flush_ctrl",    128'(out_ctrl),  128'(0));
        chk("flush_data",    128'(out_data),  128'(0));
        chk("flush_occ",     128'(occupancy), 128'(0));
        chk("flush_inready", 128'(in_ready),  128'(1));
        tick();
        chk("flush_no_ghost", 128'(out_valid), 128'(0));

        // Backpressure saturation: hold one beat for 20 stalled cycles.
        drive(1'b1, 8'h33, 128'h33, 1'b0);
        tick();
        drive(1'b0, '0, '0, '0);
        repeat (20) tick();
        chk("bp_saturated", 128'(bp_count), 128'(BP_MAX));

        // Asynchronous reset between edges while FULL.
        drive(1'b1, 8'h44, 128'h44, 1'b1);
        tick();
        chk("pre_reset_occ", 128'(occupancy), 128'(2));
        drive(1'b0, '0, '0, '0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_ctrl",  128'(out_ctrl),  128'(0));
        chk("arst_data",  128'(out_data),  128'(0));
        chk("arst_pulse", 128'(out_pulse), 128'(0));
        chk("arst_occ",   128'(occupancy), 128'(0));
        chk("arst_bp",    128'(bp_count),  128'(0));
        model_reset();
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'h77, 128'h77, 1'b1);
        tick();
        chk("post_reset_valid", 128'(out_valid), 128'(1));
        chk("post_reset_data",  128'(out_data),  128'h77);
        drive(1'b0, '0, '0, '0);
        tick();

        // Random traffic in two phases: light and heavy backpressure.
        for (int i = 0; i < 600; i++) begin
            logic v;
            v = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            out_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 24) == 0);
            drive(v, CTRL_W'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  PULSE_W'($urandom));
            tick();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
